// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet round-robin arbiter.
package pkt_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request at or after ptr, wrapping to index 0.
// Latency: purely combinational. Backpressure: none, pure function of inputs.
module rr_pick #(
    parameter int NB_REQ = 4,
    parameter int IDX_W  = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Descending scans so the lowest qualifying index is the last one written.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign found = |req;
    assign idx   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-level round-robin arbiter muxing NB_REQ requesters onto one master port; stats via PKT_ARB_STATS_EN.
// Latency: one cycle of arbitration, then the granted requester passes through combinationally.
// Backpressure: rtr_i is routed only to the granted requester; the grant holds until its eow transfer.
module pkt_rr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter  int NB_REQ = 4,
    parameter  int DATA_W = 8,
    localparam int IDX_W  = $clog2(NB_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NB_REQ-1:0]           iff_rts,
    input  logic [NB_REQ-1:0]           iff_sow,
    input  logic [NB_REQ-1:0]           iff_eow,
    input  logic [NB_REQ*DATA_W-1:0]    iff_data,
    output logic [NB_REQ-1:0]           off_rtr,
    output logic                        rts_o,
    output logic                        sow_o,
    output logic                        eow_o,
    output logic [DATA_W-1:0]           data_o,
    input  logic                        rtr_i,
    output logic [IDX_W-1:0]            grant_o,
    output logic                        busy_o,
    output logic [NB_REQ*PKT_CNT_W-1:0] pkt_cnt_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             lock;
    logic             eow_xfer;

    rr_pick #(
        .NB_REQ (NB_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req    (iff_rts & iff_sow),
        .ptr    (ptr_q),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    assign lock     = (state_q == LOCK);
    assign eow_xfer = rts_o & rtr_i & eow_o;

    // Master side follows the granted requester; everything is quiet in IDLE.
    always_comb begin
        off_rtr = '0;
        rts_o   = 1'b0;
        sow_o   = 1'b0;
        eow_o   = 1'b0;
        data_o  = '0;
        if (lock) begin
            for (int i = 0; i < NB_REQ; i++) begin
                if (grant_q == IDX_W'(i)) begin
                    off_rtr[i] = rtr_i;
                    rts_o      = iff_rts[i];
                    sow_o      = iff_sow[i];
                    eow_o      = iff_eow[i];
                    data_o     = iff_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (eow_xfer) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = lock;

`ifdef PKT_ARB_STATS_EN
    logic [PKT_CNT_W-1:0] cnt_q [NB_REQ];
    logic [PKT_CNT_W-1:0] cnt_d [NB_REQ];

    // Counters wrap naturally at 16 bits.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NB_REQ; i++) begin
            if (eow_xfer && grant_q == IDX_W'(i)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pkt_cnt_o = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            pkt_cnt_o[i*PKT_CNT_W +: PKT_CNT_W] = cnt_q[i];
        end
    end
`else
    assign pkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: single packet, single-beat alternation, fairness,
// backpressure, reset mid-packet and the packet counters.
module tb_pkt_rr_arbiter;

    localparam int NB = 4;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NB-1:0]    iff_rts, iff_sow, iff_eow;
    logic [NB*DW-1:0] iff_data;
    logic [NB-1:0]    off_rtr;
    logic             rts_o, sow_o, eow_o;
    logic [DW-1:0]    data_o;
    logic             rtr_i;
    logic [1:0]       grant_o;
    logic             busy_o;
    logic [NB*16-1:0] pkt_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pkt_rr_arbiter #(.NB_REQ(NB), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .iff_rts   (iff_rts),
        .iff_sow   (iff_sow),
        .iff_eow   (iff_eow),
        .iff_data  (iff_data),
        .off_rtr   (off_rtr),
        .rts_o     (rts_o),
        .sow_o     (sow_o),
        .eow_o     (eow_o),
        .data_o    (data_o),
        .rtr_i     (rtr_i),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .pkt_cnt_o (pkt_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [1:0] i, input logic r, input logic s, input logic e,
                           input logic [7:0] d);
        iff_rts[i]                = r;
        iff_sow[i]                = s;
        iff_eow[i]                = e;
        iff_data[{i, 3'b000} +: DW] = d;
    endtask

    function automatic logic [7:0] bd(input int i, input int b);
        return 8'(16 * (i + 1) + b);
    endfunction

    logic [7:0] t1_dat [3] = '{8'hA1, 8'hB2, 8'hC3};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, beat, xfers;
        logic [3:0] oh;

        rst = 1'b1; iff_rts = '0; iff_sow = '0; iff_eow = '0; iff_data = '0; rtr_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        samp();
        chk("rst_outs", {busy_o, rts_o, sow_o, eow_o, data_o, off_rtr}, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_cnt", pkt_cnt_o, 0);

        // Single requester, 3-beat packet.
        tick();
        rtr_i = 1'b1;
        set_req(0, 1, 1, 0, t1_dat[0]);
        samp();
        chk("t1_idle_busy", busy_o, 0);
        chk("t1_idle_rtr", off_rtr, 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            samp();
            chk("t1_grant", grant_o, 0);
            chk("t1_busy", busy_o, 1);
            chk("t1_data", data_o, t1_dat[b]);
            chk("t1_sow", sow_o, (b == 0));
            chk("t1_eow", eow_o, (b == 2));
            chk("t1_rtr", off_rtr, 4'b0001);
            tick();
            if (b < 2) set_req(0, 1, 0, (b == 1), t1_dat[b+1]);
            else       set_req(0, 0, 0, 0, 8'h00);
        end
        samp();
        chk("t1_done_busy", busy_o, 0);
        chk("t1_done_rts", rts_o, 0);

        // Single-beat packets on req1/req3 alternate, two cycles each.
        tick();
        set_req(1, 1, 1, 1, 8'h11);
        set_req(3, 1, 1, 1, 8'h33);
        for (int p = 0; p < 4; p++) begin
            samp();
            chk("t5_idle_busy", busy_o, 0);
            tick();
            samp();
            chk("t5_grant", grant_o, (p % 2 == 0) ? 1 : 3);
            chk("t5_data", data_o, (p % 2 == 0) ? 8'h11 : 8'h33);
            chk("t5_eow", eow_o, 1);
            tick();
        end
        set_req(1, 0, 0, 0, 8'h00);
        set_req(3, 0, 0, 0, 8'h00);

        // Fairness: all four hold 2-beat packets continuously.
        for (int i = 0; i < NB; i++) set_req(2'(i), 1, 1, 0, bd(i, 0));
        for (int p = 0; p < 5; p++) begin
            g  = p % 4;
            oh = 4'b0001 << g;
            samp();
            chk("t2_idle_busy", busy_o, 0);
            tick();
            samp();
            chk("t2_grant", grant_o, g);
            chk("t2_beat0", data_o, bd(g, 0));
            chk("t2_rtr", off_rtr, oh);
            tick();
            set_req(2'(g), 1, 0, 1, bd(g, 1));
            samp();
            chk("t2_beat1", data_o, bd(g, 1));
            chk("t2_eow", eow_o, 1);
            tick();
            if (p < 4) set_req(2'(g), 1, 1, 0, bd(g, 0));
            else begin
                iff_rts = '0; iff_sow = '0; iff_eow = '0;
            end
        end

        // Backpressure on a 4-beat req1 packet; req3 has rts but no sow.
        set_req(1, 1, 1, 0, bd(1, 0));
        set_req(3, 1, 0, 0, 8'h77);
        samp();
        tick();
        beat  = 0;
        xfers = 0;
        for (int k = 0; k < 20 && beat < 4; k++) begin
            rtr_i = (k % 2 == 0);
            samp();
            chk("t3_rtr", off_rtr, {2'b00, rtr_i, 1'b0});
            chk("t3_data", data_o, bd(1, beat));
            if (rts_o & rtr_i) xfers++;
            tick();
            if (rtr_i) begin
                beat++;
                if (beat < 4) set_req(1, 1, 0, (beat == 3), bd(1, beat));
                else          set_req(1, 0, 0, 0, 8'h00);
            end
        end
        rtr_i = 1'b1;
        set_req(3, 0, 0, 0, 8'h00);
        chk("t3_xfers", xfers, 4);
        samp();
        chk("t3_done_busy", busy_o, 0);

        // Reset in the middle of a 4-beat req3 packet, then a fresh req2 packet.
        tick();
        set_req(3, 1, 1, 0, bd(3, 0));
        samp();
        tick();
        samp();
        chk("t4_grant", grant_o, 3);
        tick();
        set_req(3, 1, 0, 0, bd(3, 1));
        samp();
        chk("t4_beat1", data_o, bd(3, 1));
        tick();
        set_req(3, 0, 0, 0, bd(3, 2));
        samp();
        chk("t4_stall_busy", busy_o, 1);
        chk("t4_stall_grant", grant_o, 3);
        chk("t4_stall_rts", rts_o, 0);
        tick();
        set_req(3, 1, 0, 0, bd(3, 2));
        rst = 1'b1;
        samp();
        chk("t4_beat2", data_o, bd(3, 2));
        tick();
        rst = 1'b0;
        set_req(3, 0, 0, 0, 8'h00);
        set_req(2, 1, 1, 1, bd(2, 0));
        samp();
        chk("t4_rst_outs", {busy_o, rts_o, sow_o, eow_o, data_o, off_rtr}, 0);
        chk("t4_rst_grant", grant_o, 0);
        tick();
        samp();
        chk("t4_new_grant", grant_o, 2);
        chk("t4_new_data", data_o, bd(2, 0));
        chk("t4_new_rtr", off_rtr, 4'b0100);
        tick();
        set_req(2, 0, 0, 0, 8'h00);
        samp();
        chk("t4_done_busy", busy_o, 0);

`ifdef PKT_ARB_STATS_EN
        chk("cnt_after_rst", pkt_cnt_o, 64'h0000_0001_0000_0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1, 1, 1, 8'h5A);
        repeat (2 * 65537) tick();
        set_req(0, 0, 0, 0, 8'h00);
        samp();
        chk("cnt_wrap", pkt_cnt_o, 64'h0000_0000_0000_0001);
`else
        chk("cnt_const", pkt_cnt_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
